// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a sequenced multiplier custom-instruction port.
// Latency: ack in the cycle after the 6th edge following the req-sampling edge when mul_done returns 1 cycle after each start.
// Backpressure: req is held until ack; a loser or late requester waits in IDLE, and each mul_done wait aborts after TIMEOUT cycles.
//
// Ports: clk/reset (async, active low); req0/req1 with operands a0,b0/a1,b1;
//        ack0/ack1, res0/res1, err0/err1 completion pulses; busy;
//        mul_dataa/mul_n/mul_start/mul_clk_en/mul_done/mul_result multiplier port.
module mul_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic signed [31:0] a0,
    input  logic signed [31:0] b0,
    input  logic signed [31:0] a1,
    input  logic signed [31:0] b1,
    output logic               ack0,
    output logic               ack1,
    output logic signed [31:0] res0,
    output logic signed [31:0] res1,
    output logic               err0,
    output logic               err1,
    output logic               busy,
    output logic [31:0]        mul_dataa,
    output logic [2:0]         mul_n,
    output logic               mul_start,
    output logic               mul_clk_en,
    input  logic               mul_done,
    input  logic signed [31:0] mul_result
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_A   = 3'd1;
    localparam logic [2:0] WAIT_A = 3'd2;
    localparam logic [2:0] WR_B   = 3'd3;
    localparam logic [2:0] WAIT_B = 3'd4;
    localparam logic [2:0] RD     = 3'd5;
    localparam logic [2:0] WAIT_R = 3'd6;
    localparam logic [2:0] RESP   = 3'd7;

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]         state;
    logic               ptr;
    logic               gnt_id;
    logic signed [31:0] a_q;
    logic signed [31:0] b_q;
    logic signed [31:0] res_q;
    logic               err_q;
    logic [CW-1:0]      cnt;

    logic               pick;
    logic               in_wait;
    logic [2:0]         wait_next;

    // With both requesting, ptr decides; otherwise the single requester wins.
    always_comb begin
        pick = (req0 && req1) ? ptr : req1;
    end

    always_comb begin
        in_wait   = 1'b0;
        wait_next = IDLE;
        case (state)
            WAIT_A: begin in_wait = 1'b1; wait_next = WR_B; end
            WAIT_B: begin in_wait = 1'b1; wait_next = RD;   end
            WAIT_R: begin in_wait = 1'b1; wait_next = RESP; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gnt_id <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else if (in_wait) begin
            if (mul_done) begin
                if (state == WAIT_R) begin
                    res_q <= mul_result;
                end
                state <= wait_next;
            end else if (cnt == CNT_LAST) begin
                // Abort: report error with a zero result.
                err_q <= 1'b1;
                res_q <= '0;
                state <= RESP;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            // Counter is cleared in every non-wait state, so it is zero on wait entry.
            cnt <= '0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id <= pick;
                        ptr    <= ~pick;
                        a_q    <= pick ? a1 : a0;
                        b_q    <= pick ? b1 : b0;
                        res_q  <= '0;
                        err_q  <= 1'b0;
                        state  <= WR_A;
                    end
                end
                WR_A:    state <= WAIT_A;
                WR_B:    state <= WAIT_B;
                RD:      state <= WAIT_R;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state so an async reset clears them without a clock edge.
    always_comb begin
        mul_start  = 1'b0;
        mul_n      = 3'd0;
        mul_dataa  = '0;
        mul_clk_en = (state != IDLE);
        busy       = (state != IDLE);
        ack0       = 1'b0;
        ack1       = 1'b0;
        res0       = '0;
        res1       = '0;
        err0       = 1'b0;
        err1       = 1'b0;
        case (state)
            WR_A: begin
                mul_start = 1'b1;
                mul_n     = 3'd0;
                mul_dataa = a_q;
            end
            WR_B: begin
                mul_start = 1'b1;
                mul_n     = 3'd1;
                mul_dataa = b_q;
            end
            RD: begin
                mul_start = 1'b1;
                mul_n     = 3'd2;
            end
            RESP: begin
                if (gnt_id) begin
                    ack1 = 1'b1;
                    res1 = res_q;
                    err1 = err_q;
                end else begin
                    ack0 = 1'b1;
                    res0 = res_q;
                    err0 = err_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

    logic               clk = 1'b0;
    logic               reset;
    logic               req0, req1;
    logic signed [31:0] a0, b0, a1, b1;
    logic               ack0, ack1;
    logic signed [31:0] res0, res1;
    logic               err0, err1;
    logic               busy;
    logic [31:0]        mul_dataa;
    logic [2:0]         mul_n;
    logic               mul_start;
    logic               mul_clk_en;
    logic               mul_done = 1'b0;
    logic signed [31:0] mul_result = '0;

    logic               done_en = 1'b1;
    logic signed [31:0] sa = '0;
    logic signed [31:0] sb = '0;

    int total = 0;
    int bad   = 0;

    logic [2:0]  st_n [8];
    logic [31:0] st_d [8];
    int          st_cnt;

    typedef struct {
        int          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          drop;
    } vec_t;

    vec_t tv [6];

    always #5 clk = ~clk;

    mul_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .res0(res0), .res1(res1),
        .err0(err0), .err1(err1),
        .busy(busy),
        .mul_dataa(mul_dataa), .mul_n(mul_n),
        .mul_start(mul_start), .mul_clk_en(mul_clk_en),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    // Multiplier model: done one cycle after each start, product on the read command.
    always @(posedge clk) begin
        mul_done <= done_en && mul_start;
        if (mul_start && mul_n == 3'd0) sa <= mul_dataa;
        if (mul_start && mul_n == 3'd1) sb <= mul_dataa;
        if (mul_start && mul_n == 3'd2) mul_result <= sa * sb;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with req already driven; returns at the negedge where ack is seen.
    task automatic wait_ack(input int who, input int drop_after, output int edges,
                            output logic [31:0] r, output logic e, output logic other);
        logic got;
        got = 1'b0; edges = 0; other = 1'b0; r = '0; e = 1'b0; st_cnt = 0;
        while (!got && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (drop_after > 0 && edges == drop_after) begin
                if (who == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            if (mul_start && st_cnt < 8) begin
                st_n[st_cnt] = mul_n;
                st_d[st_cnt] = mul_dataa;
                st_cnt++;
            end
            if ((who == 0) ? (ack1 || err1) : (ack0 || err0)) other = 1'b1;
            if ((who == 0) ? ack0 : ack1) begin
                got = 1'b1;
                r   = (who == 0) ? res0 : res1;
                e   = (who == 0) ? err0 : err1;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic idle_after(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_ack_after"}, {30'd0, ack1, ack0}, 32'd0);
    endtask

    initial begin
        int          edges;
        logic [31:0] r;
        logic        e;
        logic        other;
        logic        seen;

        tv[0] = '{0, 32'd3,          32'd4,          32'd12,         0};
        tv[1] = '{1, 32'd10,         32'hFFFFFF6A,   32'hFFFFFA24,   0};
        tv[2] = '{0, 32'hFFFFFFF9,   32'hFFFFFFF8,   32'h00000038,   2};
        tv[3] = '{1, 32'h00010000,   32'h00010000,   32'h00000000,   0};
        tv[4] = '{0, 32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   0};
        tv[5] = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   4};

        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_clk_en", 32'(mul_clk_en), 32'd0);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_res0", res0, 32'd0);
        reset = 1'b1;

        // Single-requester vectors.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tv[i].who == 0) begin a0 = tv[i].a; b0 = tv[i].b; req0 = 1'b1; end
            else                begin a1 = tv[i].a; b1 = tv[i].b; req1 = 1'b1; end
            wait_ack(tv[i].who, tv[i].drop, edges, r, e, other);
            req0 = 1'b0; req1 = 1'b0;
            chk($sformatf("v%0d_latency", i), 32'(edges), 32'd7);
            chk($sformatf("v%0d_res", i), r, tv[i].res);
            chk($sformatf("v%0d_err", i), 32'(e), 32'd0);
            chk($sformatf("v%0d_other", i), 32'(other), 32'd0);
            chk($sformatf("v%0d_nstarts", i), 32'(st_cnt), 32'd3);
            chk($sformatf("v%0d_n0", i), {st_n[1], st_n[0]}, {3'd1, 3'd0});
            chk($sformatf("v%0d_n2", i), 32'(st_n[2]), 32'd2);
            chk($sformatf("v%0d_da", i), st_d[0], tv[i].a);
            chk($sformatf("v%0d_db", i), st_d[1], tv[i].b);
            chk($sformatf("v%0d_dr", i), st_d[2], 32'd0);
            idle_after($sformatf("v%0d", i));
        end

        // Timeout abort in WAIT_A.
        done_en = 1'b0;
        @(negedge clk);
        a0 = 32'd9; b0 = 32'd9; req0 = 1'b1;
        wait_ack(0, 0, edges, r, e, other);
        req0 = 1'b0;
        chk("to_latency", 32'(edges), 32'd18);
        chk("to_err", 32'(e), 32'd1);
        chk("to_res", r, 32'd0);
        chk("to_other", 32'(other), 32'd0);
        chk("to_nstarts", 32'(st_cnt), 32'd1);
        idle_after("to");
        done_en = 1'b1;

        // Fresh reset so ptr=0, then simultaneous requests.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        a0 = 32'd7; b0 = 32'd6; a1 = 32'hFFFFFFFE; b1 = 32'd5;
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 0, edges, r, e, other);
        req0 = 1'b0;
        chk("sim1_first_lat", 32'(edges), 32'd7);
        chk("sim1_res0", r, 32'd42);
        chk("sim1_other", 32'(other), 32'd0);
        wait_ack(1, 0, edges, r, e, other);
        req1 = 1'b0;
        chk("sim1_second_lat", 32'(edges), 32'd8);
        chk("sim1_res1", r, 32'hFFFFFFF6);
        chk("sim1_other2", 32'(other), 32'd0);
        idle_after("sim1");

        // ptr now 0 again: simultaneous -> req0 first.
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 0, edges, r, e, other);
        req0 = 1'b0;
        chk("sim2_first0", 32'(other), 32'd0);
        wait_ack(1, 0, edges, r, e, other);
        req1 = 1'b0;
        chk("sim2_res1", r, 32'hFFFFFFF6);
        idle_after("sim2");

        // Lone req0 moves ptr to 1: next simultaneous -> req1 first.
        @(negedge clk);
        req0 = 1'b1;
        wait_ack(0, 0, edges, r, e, other);
        req0 = 1'b0;
        idle_after("solo");
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(1, 0, edges, r, e, other);
        req1 = 1'b0;
        chk("sim3_first1", 32'(other), 32'd0);
        chk("sim3_res1", r, 32'hFFFFFFF6);
        wait_ack(0, 0, edges, r, e, other);
        req0 = 1'b0;
        chk("sim3_res0", r, 32'd42);
        idle_after("sim3");

        // Async reset while in WAIT_B.
        @(negedge clk);
        a0 = 32'd5; b0 = 32'd5; req0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_start", 32'(mul_start), 32'd0);
        chk("mid_clk_en", 32'(mul_clk_en), 32'd0);
        @(negedge clk);
        req0 = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1 || err0 || err1) seen = 1'b1;
        end
        chk("mid_no_ack", 32'(seen), 32'd0);
        reset = 1'b1;
        a1 = 32'd2; b1 = 32'd3; req1 = 1'b1;
        wait_ack(1, 0, edges, r, e, other);
        req1 = 1'b0;
        chk("post_rst_lat", 32'(edges), 32'd7);
        chk("post_rst_res1", r, 32'd6);
        chk("post_rst_err", 32'(e), 32'd0);
        chk("post_rst_other", 32'(other), 32'd0);
        idle_after("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent in any wait state for mul_done before abort.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 req0, req1  in  1 each  SHALL be the requester 0/1 operation requests, held high until acked.
REQ-005 a0, b0, a1, b1  in  32 each, signed  SHALL be the requester operands; they are stable while the matching req is high.
REQ-006 ack0, ack1  out  1 each  SHALL be single-cycle completion pulses.
REQ-007 res0, res1  out  32 each, signed  SHALL carry the product, valid while the matching ack is high.
REQ-008 err0, err1  out  1 each  SHALL flag a timeout abort, valid with ack.
REQ-009 busy  out  1  SHALL be high in every state except IDLE.
REQ-010 mul_dataa  out  32, mul_n  out  3, mul_start  out  1, mul_clk_en  out  1  SHALL drive the multiplier custom-instruction port.
REQ-011 mul_done  in  1, mul_result  in  32 signed  SHALL be the multiplier completion flag and result.

Function
REQ-012 FSM states SHALL be IDLE, WR_A, WAIT_A, WR_B, WAIT_B, RD, WAIT_R, RESP.
REQ-013 IDLE, any req high: grant per priority pointer (ptr), latch the granted a/b and the requester id, go to WR_A.
REQ-014 Arbitration SHALL be round-robin: with both reqs high, requester ptr wins; with one high, it wins; after each grant, ptr SHALL point to the other requester.
REQ-015 WR_A: mul_start=1, mul_n=0, mul_dataa=latched a, for exactly one cycle, then WAIT_A.
REQ-016 WR_B: mul_start=1, mul_n=1, mul_dataa=latched b, one cycle, then WAIT_B.
REQ-017 RD: mul_start=1, mul_n=2, mul_dataa=0, one cycle, then WAIT_R.
REQ-018 WAIT_A/WAIT_B/WAIT_R: advance to WR_B/RD/RESP on the first edge with mul_done=1; WAIT_R SHALL capture mul_result on that edge.
REQ-019 mul_done SHALL be ignored outside the WAIT_* states.
REQ-020 Each wait state SHALL keep a cycle counter, cleared on entry; when it reaches TIMEOUT without mul_done, set the error flag and go to RESP with the captured result forced to 0.
REQ-021 RESP: assert ack and res (and err if aborted) for the granted requester only, for one cycle, then IDLE; the other requester's outputs SHALL stay 0.
REQ-022 res SHALL equal mul_result bit-for-bit, with no truncation, extension or overflow handling.
REQ-023 mul_clk_en SHALL be 1 in every state except IDLE; mul_start, mul_n and mul_dataa SHALL be 0 outside WR_A/WR_B/RD.
REQ-024 Latency with mul_done returned one cycle after each start: ack SHALL be high in the cycle after the 6th rising edge following the edge that samples req.
REQ-025 If the granted req drops mid-operation, the sequence SHALL still complete and pulse ack.
REQ-026 A req still high in the ack cycle SHALL NOT be regranted until IDLE is reached; requesters deassert req after ack.
REQ-027 New requests arriving during a sequence SHALL wait, with no loss and no effect on the current sequence.

Reset
REQ-028 reset low SHALL immediately force state IDLE, ptr=0, all counters, latches and outputs to 0, independent of clk.
REQ-029 reset asserted mid-sequence SHALL abort silently: no ack and no err.
REQ-030 The first rising edge after reset release SHALL be able to sample req.

Verification
REQ-031 req0 with a0=3, b0=4, mul_done one cycle after each start -> mul_n sequence 0,1,2 with dataa 3,4,0; ack0 pulse, res0=12, err0=0, ack1 stays 0; latency per REQ-024.
REQ-032 req1 with a1=10, b1=-150 -> res1=-1500 (0xFFFFFA24) with ack1.
REQ-033 After reset, req0 (7,6) and req1 (-2,5) raised on the same edge -> ack0 with res0=42 first, then ack1 with res1=-10; repeated simultaneous requests alternate, starting with req0.
REQ-034 req0 with mul_done tied 0 -> after TIMEOUT=16 cycles in WAIT_A: ack0=1, err0=1, res0=0, then IDLE with busy=0.
REQ-035 reset pulled low during WAIT_B with no clock edge -> busy, mul_start and mul_clk_en are 0 immediately, and no ack follows; after release, req1 (2,3) returns res1=6.
